// File: rtl/apb_master_arbiter_pkg.sv
// Shared state and command types for the APB master arbiter.
// Command struct widths track the default bus widths below.
package apb_master_arbiter_pkg;

  localparam int APB_ADDR_W = 16;
  localparam int APB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// Requester-side and APB-side signals of the arbiter; master = arbiter view,
// slave = the surrounding requesters plus the APB slave.
interface apb_master_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) ();

  logic [NUM_REQ-1:0]        i_req_valid;
  logic [NUM_REQ-1:0]        i_req_write;
  logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
  logic [NUM_REQ*DATA_W-1:0] i_req_wdata;
  logic [NUM_REQ-1:0]        o_req_done;
  logic                      o_req_err;
  logic [DATA_W-1:0]         o_req_rdata;

  logic                      o_psel;
  logic                      o_penable;
  logic                      o_pwrite;
  logic [ADDR_W-1:0]         o_paddr;
  logic [DATA_W-1:0]         o_pwdata;
  logic                      i_pready;
  logic [DATA_W-1:0]         i_prdata;
  logic                      i_pslverr;

  modport master (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    input  i_pready, i_prdata, i_pslverr,
    output o_req_done, o_req_err, o_req_rdata,
    output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata,
    output i_pready, i_prdata, i_pslverr,
    input  o_req_done, o_req_err, o_req_rdata,
    input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from the pointer;
// the pointer moves to grant+1 when advance is asserted with any request.
module rr_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         pclk,
  input  logic         pnreset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] cand;

  // Walk from farthest to nearest so the first requester at/after ptr wins.
  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    cand  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr_q) + i) % N);
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        ptr_d       = (cand == PW'(N - 1)) ? '0 : cand + 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge pnreset) begin
    if (!pnreset) begin
      ptr_q <= '0;
    end else if (advance && |req) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB3 master shared by NUM_REQ requesters with round-robin grant; all outputs registered.
// Define APB_ARB_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master_arbiter
  import apb_master_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int APB_ADDR_WIDTH = APB_ADDR_W,
  parameter int APB_DATA_WIDTH = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                  pclk,
  input logic                  pnreset,
  apb_master_arbiter_if.master bus
);

  apb_state_e                state_q;
  apb_cmd_t                  cmd_q;
  apb_cmd_t                  win_cmd;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        gnt_q;
  logic [NUM_REQ-1:0]        done_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      err_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      arb_advance;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

  assign arb_advance = (state_q == IDLE);

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .pclk    (pclk),
    .pnreset (pnreset),
    .req     (bus.i_req_valid),
    .advance (arb_advance),
    .grant   (grant)
  );

  always_comb begin
    win_cmd = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        win_cmd.write = bus.i_req_write[k];
        win_cmd.addr  = bus.i_req_addr[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
        win_cmd.wdata = bus.i_req_wdata[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge pclk or negedge pnreset) begin
    if (!pnreset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.i_req_valid) begin
            cmd_q   <= win_cmd;
            gnt_q   <= grant;
            psel_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          cnt_q     <= '0;
`endif
        end
        ACCESS: begin
          if (bus.i_pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= bus.i_pslverr;
            rdata_q   <= cmd_q.write ? '0 : bus.i_prdata;
            state_q   <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          // Abort path: any pready arriving after this is ignored outside ACCESS.
          else if (timeout) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            done_q    <= gnt_q;
            err_q     <= 1'b1;
            rdata_q   <= '0;
            state_q   <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        DONE: begin
          done_q  <= '0;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_done  = done_q;
  assign bus.o_req_err   = err_q;
  assign bus.o_req_rdata = rdata_q;
  assign bus.o_psel      = psel_q;
  assign bus.o_penable   = penable_q;
  assign bus.o_pwrite    = cmd_q.write;
  assign bus.o_paddr     = cmd_q.addr;
  assign bus.o_pwdata    = cmd_q.wdata;

endmodule
